cs_window_filter: RTL

- Parametrised successor to the chip's fixed 9-tap, 8-bit CS filter.
- Keeps a sliding window of the last DEPTH accepted samples and a running sum.
- Selects X_appr, the largest window entry not exceeding the window mean, and emits Y = (sum + DEPTH*X_appr) >> SHIFT.
- Adds over the fixed block: input valid qualification, a synchronous flush, and a debug mode that outputs X_appr directly. Sits in the multimedia datapath between the sample source and the downstream block.

---
 rtl/cs_pkg.sv | 26 ++
 rtl/cs_appr_select.sv | 36 +++
 rtl/cs_window_filter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cs_pkg.sv
// Shared constants and helpers for the CS window filter.
// Default geometry, derived widths and output mode encodings.
package cs_pkg;

    localparam int CS_DW    = 8;
    localparam int CS_DEPTH = 9;
    localparam int CS_SHIFT = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int CS_SUM_W = CS_DW + clog2(CS_DEPTH);
    localparam int CS_OW    = CS_DW + clog2(CS_DEPTH) + 1 - CS_SHIFT;

    localparam logic CS_MODE_FILT = 1'b0;
    localparam logic CS_MODE_APPR = 1'b1;

endpackage

// File: rtl/cs_appr_select.sv
// Picks X_appr: the largest window entry whose value times DEPTH does not exceed the sum.
// Comparing e*DEPTH against the sum avoids computing the mean with a divider.
module cs_appr_select
    import cs_pkg::*;
#(
    parameter int DW    = CS_DW,
    parameter int DEPTH = CS_DEPTH,
    parameter int SUM_W = DW + clog2(DEPTH)
) (
    input  logic [DEPTH*DW-1:0] win_i,
    input  logic [SUM_W-1:0]    sum_i,
    output logic [DW-1:0]       x_appr_o
);

    localparam int LW = clog2(DEPTH);
    localparam int NP = 1 << LW;

    // Heap-ordered max tree: leaves at NP..2*NP-1, root at 1.
    logic [DW-1:0] node [1:2*NP-1];

    always_comb begin
        for (int i = 1; i < 2*NP; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((SUM_W'(win_i[i*DW +: DW]) * SUM_W'(DEPTH)) <= sum_i) begin
                node[NP + i] = win_i[i*DW +: DW];
            end
        end
        for (int i = NP - 1; i >= 1; i--) begin
            node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
        end
        x_appr_o = node[1];
    end

endmodule

// File: rtl/cs_window_filter.sv
// Sliding-window CS filter: y = (sum + DEPTH*X_appr) >> SHIFT once the window is full.
// Holds the window shift register, running sum, fill count and the output register.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int DW    = CS_DW,
    parameter int DEPTH = CS_DEPTH,
    parameter int SHIFT = CS_SHIFT,
    localparam int OW   = DW + clog2(DEPTH) + 1 - SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    input  logic [DW-1:0] x,
    input  logic          mode,
    input  logic          flush,
    output logic          y_valid,
    output logic [OW-1:0] y
);

    localparam int SUM_W = DW + clog2(DEPTH);
    localparam int TW    = SUM_W + 1;
    localparam int CW    = clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0]       win_q [DEPTH];
    logic [DW-1:0]       win_d [DEPTH];
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                fire_q, fire_d;
    logic                y_valid_q, y_valid_d;
    logic [OW-1:0]       y_q, y_d;

    logic [DEPTH*DW-1:0] win_flat;
    logic [DW-1:0]       x_appr;
    logic [DW-1:0]       oldest;
    logic [TW-1:0]       total;

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            win_flat[i*DW +: DW] = win_q[i];
        end
    end

    cs_appr_select #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .SUM_W (SUM_W)
    ) u_appr_select (
        .win_i    (win_flat),
        .sum_i    (sum_q),
        .x_appr_o (x_appr)
    );

    always_comb begin
        win_d  = win_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        oldest = (cnt_q == CNT_FULL) ? win_q[DEPTH-1] : '0;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_d[i] = '0;
            end
            sum_d = '0;
            cnt_d = '0;
        end

        // Flush takes effect first, so a same-edge sample starts a fresh window.
        if (x_valid) begin
            mode_d = mode;
            if (flush) begin
                win_d[0] = x;
                sum_d    = SUM_W'(x);
                cnt_d    = CW'(1);
            end else begin
                for (int i = DEPTH - 1; i >= 1; i--) begin
                    win_d[i] = win_q[i-1];
                end
                win_d[0] = x;
                sum_d    = sum_q + SUM_W'(x) - SUM_W'(oldest);
                cnt_d    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
            end
        end

        fire_d = x_valid && !flush && (cnt_d == CNT_FULL);

        total     = TW'(sum_q) + TW'(SUM_W'(DEPTH) * SUM_W'(x_appr));
        y_valid_d = fire_q && !flush;
        y_d       = y_q;
        if (y_valid_d) begin
            y_d = (mode_q == CS_MODE_APPR) ? OW'(x_appr) : OW'(total >> SHIFT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= CS_MODE_FILT;
            fire_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_q       <= '0;
        end else begin
            win_q     <= win_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            fire_q    <= fire_d;
            y_valid_q <= y_valid_d;
            y_q       <= y_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y       = y_q;

endmodule
